// File: rtl/fp_operand_bank.sv
// fp_operand_bank
//   Avalon-MM slave holding NUM_OPERANDS software-written operand registers.
//   A LAUNCH write copies every shadow operand into the hold registers in one
//   cycle. The hold registers feed a downstream FP datapath over a
//   valid/ready handshake. The returned result is captured and can raise an
//   interrupt. The shadow/hold split lets software stage the next operand set
//   while the current one is still waiting for the consumer.
//
// Ports:
//   clk, reset           single clock; synchronous active-high reset
//   address, chipselect,
//   write_n, writedata   Avalon-MM write side (we = chipselect & ~write_n)
//   readdata             combinational read mux of address
//   op_data, op_valid,
//   op_ready             operand hand-off; operand k at [k*DATA_WIDTH +: DATA_WIDTH]
//   res_data, res_valid  result return, res_valid is a single-cycle strobe
//   irq                  done & irq_en
//
// Register map (N = NUM_OPERANDS):
//   0..N-1  OPERAND[k] shadow, R/W
//   N       CONTROL   bit0 LAUNCH (write only, reads 0)
//   N+1     STATUS    bit0 op_valid, bit1 done (W1C), bit2 overflow (W1C), bit3 busy
//   N+2     RESULT    RO
//   N+3     IRQ_EN    bit0, R/W
module fp_operand_bank #(
  parameter int DATA_WIDTH   = 32,
  parameter int NUM_OPERANDS = 4,
  parameter int ADDR_WIDTH   = 3
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [ADDR_WIDTH-1:0]              address,
  input  logic                               chipselect,
  input  logic                               write_n,
  input  logic [DATA_WIDTH-1:0]              writedata,
  output logic [DATA_WIDTH-1:0]              readdata,
  output logic [NUM_OPERANDS*DATA_WIDTH-1:0] op_data,
  output logic                               op_valid,
  input  logic                               op_ready,
  input  logic [DATA_WIDTH-1:0]              res_data,
  input  logic                               res_valid,
  output logic                               irq
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_CTRL   = ADDR_WIDTH'(NUM_OPERANDS);
  localparam logic [ADDR_WIDTH-1:0] ADDR_STATUS = ADDR_WIDTH'(NUM_OPERANDS + 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_RESULT = ADDR_WIDTH'(NUM_OPERANDS + 2);
  localparam logic [ADDR_WIDTH-1:0] ADDR_IRQEN  = ADDR_WIDTH'(NUM_OPERANDS + 3);

  logic [DATA_WIDTH-1:0]              shadow_q [NUM_OPERANDS];
  logic [NUM_OPERANDS*DATA_WIDTH-1:0] hold_q;
  logic [DATA_WIDTH-1:0]              result_q;
  logic                               op_valid_q;
  logic                               done_q;
  logic                               overflow_q;
  logic                               busy_q;
  logic                               irq_en_q;

  logic we;
  logic launch_wr;
  logic launch_acc;
  logic launch_rej;
  logic handshake;
  logic clr_done;
  logic clr_overflow;

  assign we         = chipselect & ~write_n;
  assign handshake  = op_valid_q & op_ready;
  assign launch_wr  = we && (address == ADDR_CTRL) && writedata[0];
  // A launch can land in the same cycle the consumer drains the current set,
  // which gives back-to-back transfers without a bubble.
  assign launch_acc = launch_wr & (~op_valid_q | op_ready);
  assign launch_rej = launch_wr & op_valid_q & ~op_ready;

  assign clr_done     = we && (address == ADDR_STATUS) && writedata[1];
  assign clr_overflow = we && (address == ADDR_STATUS) && writedata[2];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NUM_OPERANDS; k++) shadow_q[k] <= '0;
      hold_q     <= '0;
      result_q   <= '0;
      op_valid_q <= 1'b0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
      busy_q     <= 1'b0;
      irq_en_q   <= 1'b0;
    end else begin
      for (int k = 0; k < NUM_OPERANDS; k++) begin
        if (we && (address == ADDR_WIDTH'(k))) shadow_q[k] <= writedata;
      end

      if (we && (address == ADDR_IRQEN)) irq_en_q <= writedata[0];

      if (launch_acc) begin
        for (int k = 0; k < NUM_OPERANDS; k++)
          hold_q[k*DATA_WIDTH +: DATA_WIDTH] <= shadow_q[k];
      end

      if (launch_acc)     op_valid_q <= 1'b1;
      else if (handshake) op_valid_q <= 1'b0;

      // Set events take priority over the W1C clear in the same cycle.
      if (res_valid) begin
        result_q <= res_data;
        done_q   <= 1'b1;
      end else if (clr_done) begin
        done_q   <= 1'b0;
      end

      if (launch_rej)        overflow_q <= 1'b1;
      else if (clr_overflow) overflow_q <= 1'b0;

      // A launch coinciding with a result leaves busy set: the result belongs
      // to the previous operand set.
      if (launch_acc)     busy_q <= 1'b1;
      else if (res_valid) busy_q <= 1'b0;
    end
  end

  always_comb begin
    readdata = '0;
    for (int k = 0; k < NUM_OPERANDS; k++) begin
      if (address == ADDR_WIDTH'(k)) readdata = shadow_q[k];
    end
    if (address == ADDR_STATUS) readdata[3:0] = {busy_q, overflow_q, done_q, op_valid_q};
    if (address == ADDR_RESULT) readdata = result_q;
    if (address == ADDR_IRQEN)  readdata[0] = irq_en_q;
  end

  assign op_data  = hold_q;
  assign op_valid = op_valid_q;
  assign irq      = done_q & irq_en_q;

endmodule

// File: tb/tb_fp_operand_bank.sv
module tb_fp_operand_bank;

  localparam int DW = 32;
  localparam int N  = 4;
  localparam int AW = 3;

  localparam logic [AW-1:0] A_CTRL   = 3'd4;
  localparam logic [AW-1:0] A_STATUS = 3'd5;
  localparam logic [AW-1:0] A_RESULT = 3'd6;
  localparam logic [AW-1:0] A_IRQEN  = 3'd7;

  logic            clk = 1'b0;
  logic            reset;
  logic [AW-1:0]   address;
  logic            chipselect;
  logic            write_n;
  logic [DW-1:0]   writedata;
  logic [DW-1:0]   readdata;
  logic [N*DW-1:0] op_data;
  logic            op_valid;
  logic            op_ready;
  logic [DW-1:0]   res_data;
  logic            res_valid;
  logic            irq;

  int n_checks = 0;
  int n_fail   = 0;

  fp_operand_bank #(.DATA_WIDTH(DW), .NUM_OPERANDS(N), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .op_data(op_data), .op_valid(op_valid), .op_ready(op_ready),
    .res_data(res_data), .res_valid(res_valid), .irq(irq)
  );

  always #5 clk = ~clk;

  // Drive a one-cycle write; returns 1 time unit after the capturing edge.
  task automatic bus_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(posedge clk); #1;
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic bus_read(input logic [AW-1:0] a, output logic [DW-1:0] d);
    address = a;
    #1;
    d = readdata;
  endtask

  task automatic test_reset;
    logic [DW-1:0] rd;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    for (int a = 0; a < 8; a++) begin
      bus_read(AW'(a), rd);
      n_checks++;
      if (rd !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_read addr=%0d got=%h exp=%h", a, rd, 32'h0);
      end
    end
    n_checks++;
    if (op_valid !== 1'b0 || irq !== 1'b0 || op_data !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs op_valid=%b irq=%b op_data=%h exp 0/0/0", op_valid, irq, op_data);
    end
  endtask

  task automatic test_launch;
    logic [DW-1:0]   rd;
    logic [N*DW-1:0] exp_ops;
    exp_ops = {32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000};
    op_ready = 1'b0;
    bus_write(3'd0, 32'h3F800000);
    bus_write(3'd1, 32'h40000000);
    bus_write(3'd2, 32'h40400000);
    bus_write(3'd3, 32'h40800000);
    bus_read(3'd2, rd);
    n_checks++;
    if (rd !== 32'h40400000) begin
      n_fail++;
      $display("FAIL operand_readback got=%h exp=%h", rd, 32'h40400000);
    end
    n_checks++;
    if (op_data !== '0 || op_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL write_no_hold op_data=%h op_valid=%b exp 0/0", op_data, op_valid);
    end
    bus_write(A_CTRL, 32'h1);
    n_checks++;
    if (op_valid !== 1'b1 || op_data !== exp_ops) begin
      n_fail++;
      $display("FAIL launch op_valid=%b op_data=%h exp 1/%h", op_valid, op_data, exp_ops);
    end
    bus_read(A_STATUS, rd);
    n_checks++;
    if (rd !== 32'h9) begin
      n_fail++;
      $display("FAIL launch_status got=%h exp=%h", rd, 32'h9);
    end
    bus_read(A_CTRL, rd);
    n_checks++;
    if (rd !== 32'h0) begin
      n_fail++;
      $display("FAIL control_read got=%h exp=%h", rd, 32'h0);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (op_valid !== 1'b1 || op_data !== exp_ops) begin
        n_fail++;
        $display("FAIL stall_stable cyc=%0d op_valid=%b op_data=%h exp 1/%h", i, op_valid, op_data, exp_ops);
      end
    end
    op_ready = 1'b1;
    @(posedge clk); #1;
    op_ready = 1'b0;
    n_checks++;
    if (op_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL handshake_drop op_valid=%b exp=0", op_valid);
    end
    bus_read(A_STATUS, rd);
    n_checks++;
    if (rd !== 32'h8) begin
      n_fail++;
      $display("FAIL status_busy_after_hs got=%h exp=%h", rd, 32'h8);
    end
  endtask

  task automatic test_overflow;
    logic [DW-1:0]   rd;
    logic [N*DW-1:0] exp_ops;
    exp_ops = {32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000};
    op_ready = 1'b0;
    bus_write(A_CTRL, 32'h1);
    bus_write(3'd0, 32'hDEADBEEF);
    bus_write(A_CTRL, 32'h1);
    n_checks++;
    if (op_valid !== 1'b1 || op_data !== exp_ops) begin
      n_fail++;
      $display("FAIL reject_hold op_valid=%b op_data=%h exp 1/%h", op_valid, op_data, exp_ops);
    end
    bus_read(A_STATUS, rd);
    n_checks++;
    if (rd !== 32'hD) begin
      n_fail++;
      $display("FAIL overflow_set got=%h exp=%h", rd, 32'hD);
    end
    bus_write(A_STATUS, 32'h4);
    bus_read(A_STATUS, rd);
    n_checks++;
    if (rd !== 32'h9) begin
      n_fail++;
      $display("FAIL overflow_clear got=%h exp=%h", rd, 32'h9);
    end
  endtask

  task automatic test_back_to_back;
    logic [N*DW-1:0] exp_ops;
    exp_ops = {32'h40800000, 32'h40400000, 32'h40000000, 32'hDEADBEEF};
    op_ready = 1'b1;
    bus_write(A_CTRL, 32'h1);
    op_ready = 1'b0;
    n_checks++;
    if (op_valid !== 1'b1 || op_data !== exp_ops) begin
      n_fail++;
      $display("FAIL back_to_back op_valid=%b op_data=%h exp 1/%h", op_valid, op_data, exp_ops);
    end
    op_ready = 1'b1;
    @(posedge clk); #1;
    op_ready = 1'b0;
    n_checks++;
    if (op_valid !== 1'b0 || op_data !== exp_ops) begin
      n_fail++;
      $display("FAIL b2b_drain op_valid=%b op_data=%h exp 0/%h", op_valid, op_data, exp_ops);
    end
  endtask

  task automatic test_result;
    logic [DW-1:0] rd;
    bus_write(A_IRQEN, 32'hFFFF_FFFF);
    bus_read(A_IRQEN, rd);
    n_checks++;
    if (rd !== 32'h1) begin
      n_fail++;
      $display("FAIL irq_en_read got=%h exp=%h", rd, 32'h1);
    end
    res_data = 32'h41200000; res_valid = 1'b1;
    @(posedge clk); #1;
    res_valid = 1'b0;
    bus_read(A_RESULT, rd);
    n_checks++;
    if (rd !== 32'h41200000) begin
      n_fail++;
      $display("FAIL result_capture got=%h exp=%h", rd, 32'h41200000);
    end
    bus_read(A_STATUS, rd);
    n_checks++;
    if (rd !== 32'h2 || irq !== 1'b1) begin
      n_fail++;
      $display("FAIL result_status status=%h irq=%b exp %h/1", rd, irq, 32'h2);
    end
    res_data = 32'h12345678; res_valid = 1'b1;
    bus_write(A_STATUS, 32'h2);
    res_valid = 1'b0;
    bus_read(A_STATUS, rd);
    n_checks++;
    if (rd !== 32'h2 || irq !== 1'b1) begin
      n_fail++;
      $display("FAIL done_set_wins status=%h irq=%b exp %h/1", rd, irq, 32'h2);
    end
    bus_read(A_RESULT, rd);
    n_checks++;
    if (rd !== 32'h12345678) begin
      n_fail++;
      $display("FAIL result_second got=%h exp=%h", rd, 32'h12345678);
    end
    bus_write(A_STATUS, 32'h2);
    bus_read(A_STATUS, rd);
    n_checks++;
    if (rd !== 32'h0 || irq !== 1'b0) begin
      n_fail++;
      $display("FAIL done_clear status=%h irq=%b exp %h/0", rd, irq, 32'h0);
    end
  endtask

  task automatic test_launch_with_result;
    logic [DW-1:0] rd;
    op_ready = 1'b0;
    res_data = 32'h3F000000; res_valid = 1'b1;
    bus_write(A_CTRL, 32'h1);
    res_valid = 1'b0;
    bus_read(A_STATUS, rd);
    n_checks++;
    if (rd !== 32'hB || irq !== 1'b1) begin
      n_fail++;
      $display("FAIL launch_wins_busy status=%h irq=%b exp %h/1", rd, irq, 32'hB);
    end
    bus_write(A_CTRL, 32'h0);
    bus_read(A_STATUS, rd);
    n_checks++;
    if (rd !== 32'hB) begin
      n_fail++;
      $display("FAIL launch_bit_clear status=%h exp=%h", rd, 32'hB);
    end
  endtask

  task automatic test_reset_mid;
    logic [DW-1:0] rd;
    op_ready = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (op_valid !== 1'b0 || irq !== 1'b0 || op_data !== '0) begin
      n_fail++;
      $display("FAIL reset_mid op_valid=%b irq=%b op_data=%h exp 0/0/0", op_valid, irq, op_data);
    end
    reset = 1'b0;
    bus_read(A_STATUS, rd);
    n_checks++;
    if (rd !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_mid_status got=%h exp=%h", rd, 32'h0);
    end
    bus_read(3'd0, rd);
    n_checks++;
    if (rd !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_mid_shadow got=%h exp=%h", rd, 32'h0);
    end
  endtask

  initial begin
    reset = 1'b1; address = '0; chipselect = 1'b0; write_n = 1'b1;
    writedata = '0; op_ready = 1'b0; res_data = '0; res_valid = 1'b0;
    test_reset();
    test_launch();
    test_overflow();
    test_back_to_back();
    test_result();
    test_launch_with_result();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fp_operand_bank.md
Name: fp_operand_bank

Overview:
- Parametrised successor to the single-word operand output port: an Avalon-MM slave holding NUM_OPERANDS software-written operand registers.
- A launch command commits all operands atomically to a downstream FP datapath over a valid/ready handshake.
- The bank captures the returned result and raises a maskable interrupt.
- Double-buffered (shadow → hold), so the CPU can stage the next operand set while the current one is still pending.

Parameters:
- DATA_WIDTH, 32: width of each operand, the result and the bus data.
- NUM_OPERANDS, 4: number of operand registers (1..16).
- ADDR_WIDTH, 3: word address width; must satisfy NUM_OPERANDS+4 <= 2**ADDR_WIDTH.

Ports:
- clk  in  1: single clock, all logic on the rising edge.
- reset  in  1: synchronous, active-high reset.
- address  in  ADDR_WIDTH: word address.
- chipselect  in  1: slave select.
- write_n  in  1: active-low write strobe, qualified by chipselect.
- writedata  in  DATA_WIDTH: write data.
- readdata  out  DATA_WIDTH: combinational read mux of address.
- op_data  out  NUM_OPERANDS*DATA_WIDTH: hold registers; operand k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- op_valid  out  1: op_data valid for the consumer.
- op_ready  in  1: consumer accepts op_data.
- res_data  in  DATA_WIDTH: result from the datapath.
- res_valid  in  1: single-cycle result strobe.
- irq  out  1: interrupt request.

Behaviour:
- Write strobe: we = chipselect & ~write_n. At most one register is written per cycle.
- Register map:
  - 0..N-1: OPERAND[k] shadow, R/W.
  - N: CONTROL, W. bit0 = LAUNCH; reads return 0.
  - N+1: STATUS. bit0 op_valid (RO), bit1 done (W1C), bit2 overflow (W1C), bit3 busy (RO); other bits read 0.
  - N+2: RESULT, RO.
  - N+3: IRQ_EN, R/W, bit0 only.
  - Unmapped addresses read 0; writes to them are ignored.
- Reset: shadow, hold, result, op_valid, done, overflow, busy and irq_en all go to 0; irq=0, op_data=0.
- Operand write: shadow[k] <= writedata; visible on readdata the next cycle. Writes never alter hold/op_data.
- Launch acceptance:
  - A LAUNCH write is accepted when !op_valid, or when op_valid & op_ready in the same cycle.
  - On accept: hold <= shadow (all operands), op_valid <= 1 next cycle, busy <= 1. Launch-to-op_valid latency is 1 cycle.
- Launch rejection: a LAUNCH while op_valid & !op_ready leaves hold and op_valid unchanged and sets overflow <= 1.
- Handshake completion: op_valid & op_ready with no accepted launch gives op_valid <= 0 next cycle. op_data must stay stable while op_valid & !op_ready.
- Simultaneous launch and handshake: the new set loads and op_valid stays 1 (back-to-back transfer, no bubble).
- Result capture:
  - res_valid gives result <= res_data, done <= 1, busy <= 0, independent of busy state.
  - res_valid in the same cycle as an accepted launch: result is captured and done is set, but busy ends at 1 (launch wins for busy).
- W1C precedence: writing 1 clears the bit. If a set event (res_valid, rejected launch) coincides with its W1C in the same cycle, set wins.
- irq = done & irq_en, driven from registers with no combinational path from bus inputs.
- Reset mid-transfer: op_valid drops on the next edge regardless of op_ready. The consumer must tolerate withdrawal on reset only.

Test Plan:
- Reset, then read all addresses → operands, RESULT, STATUS and IRQ_EN read 0; op_valid=0, irq=0.
- N=4: write 0x3F800000, 0x40000000, 0x40400000, 0x40800000 to addrs 0..3, then LAUNCH with op_ready=0 → next cycle op_valid=1 with op_data in that order; STATUS=0x9. Hold op_ready low 5 cycles → op_data stable. Pulse op_ready → op_valid=0 next cycle.
- With op_valid=1 and op_ready=0, rewrite addr0=0xDEADBEEF and LAUNCH → op_data unchanged, STATUS bit2=1. Write 0x4 to STATUS → bit2 clears.
- With op_valid=1, issue LAUNCH in the same cycle as op_ready=1 → op_valid stays 1 and op_data shows the new shadow set next cycle.
- IRQ_EN=1, res_data=0x41200000 with res_valid for 1 cycle → RESULT=0x41200000, done=1, busy=0, irq=1. Write 0x2 to STATUS in the same cycle as a second res_valid → done stays 1. Write 0x2 alone → irq=0.
- Assert reset while op_valid=1 and done=1 → all outputs 0 on the next edge.
